// File: rtl/mrd_fsmsource.sv
// mrd_fsmsource: replays a frame stored across 7 interleaved banks into a credit-limited output FIFO.
module mrd_fsmsource #(
  parameter int wADDR = 8,
  parameter int wDATA = 36,
  parameter int RD_LAT = 2,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [11:0]        len,
  output logic [wADDR-1:0]   rdaddr,
  output logic [6:0]         rden,
  input  logic [7*wDATA-1:0] rddata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [wDATA-1:0]   out_data,
  output logic               out_sop,
  output logic               out_eop,
  output logic               busy,
  output logic               done,
  output logic               err_start
);
  localparam int wP = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int wC = $clog2(DEPTH + 1);
  if (DEPTH < RD_LAT + 2) begin : g_depth_chk
    $error("mrd_fsmsource: DEPTH must be >= RD_LAT+2");
  end
  if (RD_LAT < 1) begin : g_lat_chk
    $error("mrd_fsmsource: RD_LAT must be >= 1");
  end
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state_q, state_d;
  logic [11:0] len_q, k_q;
  logic [2:0] bank_q;
  logic [wADDR-1:0] addr_q;
  logic [RD_LAT-1:0] pv_q, ps_q, pe_q;
  logic [RD_LAT-1:0][2:0] pb_q;
  logic [wDATA+1:0] mem_q [DEPTH];
  logic [wDATA+1:0] head;
  logic [wP-1:0] wp_q, rp_q;
  logic [wC-1:0] cnt_q;
  logic done_q, err_q, issue, last, push, pop;
  // credit counts both queued entries and reads still in the RAM pipeline
  always_comb begin
    issue = state_q == READ && (int'(cnt_q) + $countones(pv_q) < DEPTH);
    last = k_q == len_q - 12'd1;
    push = pv_q[RD_LAT-1];
    pop = out_valid && out_ready;
    head = mem_q[rp_q];
  end
  always_comb begin
    state_d = (state_q == IDLE && start && len != 12'd0) ? READ :
              (state_q == READ && issue && last) ? DRAIN :
              (state_q == DRAIN && pop && out_eop) ? IDLE : state_q;
  end
  always_comb begin
    out_valid = cnt_q != '0;
    out_data = out_valid ? head[wDATA-1:0] : '0;
    out_sop = out_valid && head[wDATA+1];
    out_eop = out_valid && head[wDATA];
    rden = issue ? 7'h40 >> bank_q : 7'h00;
    rdaddr = addr_q;
    busy = state_q != IDLE;
    done = done_q;
    err_start = err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q <= '0;
      k_q <= '0;
      bank_q <= '0;
      addr_q <= '0;
      pv_q <= '0;
      ps_q <= '0;
      pe_q <= '0;
      pb_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q <= (state_q == IDLE && start && len == 12'd0) || (state_q == DRAIN && pop && out_eop);
      err_q <= start && state_q != IDLE;
      if (state_q == IDLE && start) begin
        len_q <= len;
        k_q <= '0;
        bank_q <= '0;
        addr_q <= '0;
      end else if (issue) begin
        k_q <= k_q + 12'd1;
        bank_q <= bank_q == 3'd6 ? 3'd0 : bank_q + 3'd1;
        addr_q <= bank_q == 3'd6 ? addr_q + 1'b1 : addr_q;
      end
      pv_q[0] <= issue;
      ps_q[0] <= k_q == 12'd0;
      pe_q[0] <= last;
      pb_q[0] <= bank_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        ps_q[i] <= ps_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pb_q[i] <= pb_q[i-1];
      end
      if (push) begin
        mem_q[wp_q] <= {ps_q[RD_LAT-1], pe_q[RD_LAT-1], rddata[int'(pb_q[RD_LAT-1])*wDATA +: wDATA]};
        wp_q <= wp_q == wP'(DEPTH - 1) ? '0 : wp_q + 1'b1;
      end
      if (pop) rp_q <= rp_q == wP'(DEPTH - 1) ? '0 : rp_q + 1'b1;
      cnt_q <= cnt_q + wC'(push) - wC'(pop);
    end
  end
endmodule

// File: tb/tb_mrd_fsmsource.sv
// tb_mrd_fsmsource: scoreboard bench with a 2-cycle banked RAM model behind the read port.
module tb_mrd_fsmsource;
  localparam int WA = 8;
  localparam int WD = 36;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst, start, out_ready;
  logic [11:0] len;
  logic [WA-1:0] rdaddr;
  logic [6:0] rden;
  logic [7*WD-1:0] rddata;
  logic out_valid, out_sop, out_eop, busy, done, err_start;
  logic [WD-1:0] out_data;
  int tests = 0, fails = 0;
  int cyc = 0, c0 = 0, iss = 0;
  int rden_cyc, valid_cyc, done_cyc, err_cyc, done_cnt, valid_cnt, rden_cnt;
  bit tog = 0, stall_prev = 0;
  logic [15:0] salt = 16'h1234;
  logic [WD+1:0] prev, got;
  logic [WD+1:0] sb [$];
  logic [6:0] en1;
  logic [WA-1:0] a1;

  mrd_fsmsource #(.wADDR(WA), .wDATA(WD), .RD_LAT(LAT), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .rdaddr(rdaddr), .rden(rden),
    .rddata(rddata), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .busy(busy), .done(done), .err_start(err_start)
  );

  always #5 clk = ~clk;

  function automatic logic [WD-1:0] f(int b, int a);
    logic [15:0] h;
    h = 16'(a * 37 + b * 101) ^ salt;
    return {4'(b), 16'(a), h};
  endfunction

  always @(posedge clk) begin
    en1 <= rden;
    a1 <= rdaddr;
    for (int b = 0; b < 7; b++) rddata[b*WD +: WD] <= en1[6-b] ? f(b, int'(a1)) : 36'hBADBADBAD;
  end

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, obs, exp, cyc - c0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rden != 7'h00) begin
        if (rden_cyc < 0) rden_cyc = cyc - c0;
        check("rden", 64'(rden), 64'(7'h40 >> (iss % 7)));
        check("rdaddr", 64'(rdaddr), 64'(iss / 7));
        iss++;
        rden_cnt++;
      end
      if (out_valid) begin
        got = {out_sop, out_eop, out_data};
        if (valid_cyc < 0) valid_cyc = cyc - c0;
        if (stall_prev) check("hold", 64'(got), 64'(prev));
        stall_prev = !out_ready;
        prev = got;
        if (out_ready) begin
          valid_cnt++;
          if (sb.size() == 0) check("spurious", 64'(1), 64'(0));
          else check("beat", 64'(got), 64'(sb.pop_front()));
        end
      end else stall_prev = 0;
      if (done) begin
        done_cyc = cyc - c0;
        done_cnt++;
      end
      if (err_start) err_cyc = cyc - c0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (tog) out_ready = ~out_ready;
  endtask

  task automatic frame_start(int n);
    salt = 16'($urandom);
    iss = 0;
    rden_cyc = -1;
    valid_cyc = -1;
    done_cyc = -1;
    err_cyc = -1;
    done_cnt = 0;
    valid_cnt = 0;
    rden_cnt = 0;
    stall_prev = 0;
    c0 = cyc;
    for (int k = 0; k < n; k++) sb.push_back({k == 0, k == n - 1, f(k % 7, k / 7)});
    start = 1'b1;
    len = 12'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    if (done_cnt == 0) check("timeout", 64'(0), 64'(1));
    tick();
    tick();
    check("sb_empty", 64'(sb.size()), 64'(0));
  endtask

  task automatic run(int n, bit t);
    out_ready = 1'b1;
    tog = t;
    frame_start(n);
    wait_done(3 * n + 20);
    tog = 0;
    out_ready = 1'b1;
  endtask

  task automatic check_idle_zero(string tag);
    check(tag, 64'({rdaddr, rden, out_valid, out_sop, out_eop, busy, done, err_start}), 64'(0));
    check({tag, "_data"}, 64'(out_data), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    len = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    check_idle_zero("reset");
    rst = 1'b0;
    tick();

    run(14, 0);
    check("n14_rden_cyc", 64'(rden_cyc), 64'(1));
    check("n14_valid_cyc", 64'(valid_cyc), 64'(4));
    check("n14_done_cyc", 64'(done_cyc), 64'(18));
    check("n14_count", 64'(valid_cnt), 64'(14));

    run(10, 1);
    check("n10_count", 64'(valid_cnt), 64'(10));
    check("n10_done_once", 64'(done_cnt), 64'(1));

    run(1, 0);
    check("n1_valid_cyc", 64'(valid_cyc), 64'(4));
    check("n1_done_cyc", 64'(done_cyc), 64'(5));

    run(0, 0);
    check("n0_done_cyc", 64'(done_cyc), 64'(1));
    check("n0_rden", 64'(rden_cnt), 64'(0));
    check("n0_valid", 64'(valid_cnt), 64'(0));

    out_ready = 1'b1;
    frame_start(20);
    repeat (4) tick();
    start = 1'b1;
    len = 12'd5;
    tick();
    start = 1'b0;
    wait_done(80);
    check("err_cyc", 64'(err_cyc), 64'(6));
    check("n20_done_cyc", 64'(done_cyc), 64'(24));
    check("n20_count", 64'(valid_cnt), 64'(20));

    frame_start(30);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_zero("midrst");
    sb.delete();
    frame_start(7);
    wait_done(40);
    check("n7_valid_cyc", 64'(valid_cyc), 64'(4));
    check("n7_done_cyc", 64'(done_cyc), 64'(11));
    check("n7_count", 64'(valid_cnt), 64'(7));

    run(7 * 256, 0);
    check("nmax_count", 64'(valid_cnt), 64'(7 * 256));
    check("nmax_done_cyc", 64'(done_cyc), 64'(7 * 256 + LAT + 2));

    run(23, 1);
    check("n23_count", 64'(valid_cnt), 64'(23));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mrd_fsmsource.md
MRD_FSMSOURCE -- requirements
Module: mrd_fsmsource

Interface
REQ-001 SHALL provide parameters: wADDR, default 8, bank address width; wDATA, default 36, sample width (18-bit I + 18-bit Q); RD_LAT, default 2, bank RAM read latency in cycles; DEPTH, default 4, output FIFO entries.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse from the memory FSM on entry to Source.
- len  in  12  frame length N in samples, sampled on start.
- rdaddr  out  wADDR  shared read address for all 7 banks.
- rden  out  7  one-hot bank read enable; bank 0 = bit 6, bank 6 = bit 0.
- rddata  in  7 x wDATA  bank read data, valid RD_LAT cycles after the matching rden.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accept.
- out_data  out  wDATA  output sample.
- out_sop  out  1  marks the first sample of the frame.
- out_eop  out  1  marks the last sample of the frame.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at frame completion.
- err_start  out  1  one-cycle pulse when start is ignored.

Function
REQ-004 Sample k (0..N-1) SHALL be read from bank k mod 7 at address floor(k/7), matching the sink write layout.
REQ-005 The bank index SHALL wrap from 6 to 0; rdaddr SHALL increment only on that wrap, and SHALL be 0 for k=0.
REQ-006 The state machine SHALL have states IDLE, READ and DRAIN.
REQ-007 IDLE with start=1 and len!=0: latch len, clear counters, go to READ; busy=1 from the next cycle.
REQ-008 IDLE with start=1 and len==0: stay in IDLE, pulse done on the next cycle, emit no samples.
REQ-009 Any start outside IDLE SHALL be ignored and SHALL pulse err_start on the next cycle.
REQ-010 READ issues one read per cycle, only while (FIFO occupancy + reads in flight) < DEPTH.
REQ-011 READ SHALL hold rden=0 on any cycle where no read is issued.
REQ-012 After issuing sample N-1, READ SHALL go to DRAIN.
REQ-013 Return data SHALL be selected from rddata by the bank index delayed RD_LAT cycles, qualified by the delayed issue flag.
REQ-014 Return data SHALL be written into the FIFO on that same cycle, together with sop (k==0) and eop (k==N-1).
REQ-015 The FIFO head SHALL drive out_valid, out_data, out_sop and out_eop; an entry pops when out_valid && out_ready.
REQ-016 out_data, out_sop and out_eop SHALL hold stable while out_valid && !out_ready.
REQ-017 Credit accounting SHALL guarantee that the FIFO never overflows.
REQ-018 On acceptance of the eop sample: go to IDLE, pulse done the next cycle, drop busy the same cycle as done.
REQ-019 Latency: start at cycle 0 with out_ready=1 -> first rden at cycle 1 -> first out_valid at cycle RD_LAT+2.
REQ-020 With out_ready held high, samples SHALL stream at one per cycle; the last sample is accepted at cycle RD_LAT+N+1.
REQ-021 Full throughput requires DEPTH >= RD_LAT+2; an elaboration-time error SHALL fire otherwise.
REQ-022 The sample counter SHALL be 12 bits, and N up to 7*2^wADDR SHALL be supported.
REQ-023 Behaviour for len > 7*2^wADDR is undefined; the block SHALL still terminate after N samples.
REQ-024 A FIFO pop and push in the same cycle SHALL leave occupancy unchanged.
REQ-025 out_sop and out_eop SHALL both be set on the single sample when N=1.

Reset
REQ-026 rst=1 SHALL force: state IDLE, FIFO empty, in-flight reads discarded, counters 0.
REQ-027 Reset values SHALL be: rdaddr=0, rden=0, out_valid=0, out_sop=0, out_eop=0, busy=0, done=0, err_start=0, out_data=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no further out_valid; start is accepted again the first cycle after rst falls.

Verification
REQ-029 N=14, out_ready=1: rden sequence 0x40,0x20,...,0x01,0x40,...; rdaddr=0 for 7 cycles then 1; sop on k=0, eop on k=13; done at cycle 18.
REQ-030 N=10, out_ready toggling 1,0: output order and data match the bank contents; out_data is stable while stalled; there is no overflow and no lost sample.
REQ-031 N=1: a single beat with sop=eop=1 at cycle 4; done at cycle 5.
REQ-032 len=0 with start: no rden, no out_valid; done at cycle 1.
REQ-033 start pulsed at cycle 5 of an N=20 frame -> err_start at cycle 6; the frame completes unaffected.
REQ-034 rst asserted at cycle 8 of an N=30 frame -> all outputs zero the next cycle; a new N=7 frame then runs correctly.
